// File: rtl/mandel_pkg.sv
// Shared types and default widths for the Mandelbrot frame scheduler.
package mandel_pkg;

  localparam int NUM_ENGINES_DEF = 4;
  localparam int CW_DEF          = 12;
  localparam int HBI_DEF         = 32;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_HOLD = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner only when en is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] win;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    if (found) grant[win] = 1'b1;
    ptr_d = ptr_q;
    if (en && found) ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mandel_scheduler.sv
// Frame sequencer: scans pixels row-major, dispatches them to free engines and
// streams one (x,y,iter) record per pixel to the framebuffer writer.
module mandel_scheduler
  import mandel_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int CW          = CW_DEF,
  parameter int HBI         = HBI_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       frame_start,
  input  logic [CW-1:0]              h_res,
  input  logic [CW-1:0]              v_res,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic [NUM_ENGINES-1:0]     eng_start,
  output logic [CW-1:0]              eng_x,
  output logic [CW-1:0]              eng_y,
  input  logic [NUM_ENGINES-1:0]     eng_ready,
  input  logic [NUM_ENGINES*HBI-1:0] eng_iter,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [CW-1:0]              pix_x,
  output logic [CW-1:0]              pix_y,
  output logic [HBI-1:0]             pix_iter,
  output fsm_t                       dbg_state
);

  localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  fsm_t                   state_q, state_d;
  logic [CW-1:0]          h_last_q, h_last_d, v_last_q, v_last_d;
  logic [CW-1:0]          x_q, x_d, y_q, y_d;
  slot_state_t            slot_q [NUM_ENGINES];
  slot_state_t            slot_d [NUM_ENGINES];
  logic [CW-1:0]          tag_x_q [NUM_ENGINES];
  logic [CW-1:0]          tag_x_d [NUM_ENGINES];
  logic [CW-1:0]          tag_y_q [NUM_ENGINES];
  logic [CW-1:0]          tag_y_d [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
  logic [CW-1:0]          eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [CW-1:0]          pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [HBI-1:0]         pix_iter_q, pix_iter_d;
  logic                   frame_done_q, frame_done_d;

  logic [NUM_ENGINES-1:0] disp_req, disp_grant, coll_req, coll_grant;
  logic                   all_free, dispatch, coll_en, load;
  logic [IW-1:0]          cidx;

  always_comb begin
    disp_req = '0;
    coll_req = '0;
    all_free = 1'b1;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      disp_req[i] = (state_q == ST_RUN) && (slot_q[i] == SLOT_FREE);
      coll_req[i] = (slot_q[i] == SLOT_HOLD);
      if (slot_q[i] != SLOT_FREE) all_free = 1'b0;
    end
  end

  // Output port is valid/ready: a record transfers on a cycle where pix_valid
  // and pix_ready are both high; while pix_valid && !pix_ready, pix_* hold.
  assign coll_en  = !pix_valid_q || pix_ready;
  assign dispatch = |disp_grant;
  assign load     = coll_en && (|coll_grant);

  rr_arbiter #(.N(NUM_ENGINES)) u_disp_arb (
    .clk  (CLK),
    .rst  (RST),
    .req  (disp_req),
    .en   (1'b1),
    .grant(disp_grant)
  );

  rr_arbiter #(.N(NUM_ENGINES)) u_coll_arb (
    .clk  (CLK),
    .rst  (RST),
    .req  (coll_req),
    .en   (coll_en),
    .grant(coll_grant)
  );

  always_comb begin
    cidx = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (coll_grant[i]) cidx = IW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    h_last_d     = h_last_q;
    v_last_d     = v_last_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    eng_start_d  = disp_grant;
    eng_x_d      = dispatch ? x_q : eng_x_q;
    eng_y_d      = dispatch ? y_q : eng_y_q;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_iter_d   = pix_iter_q;
    slot_d       = slot_q;
    tag_x_d      = tag_x_q;
    tag_y_d      = tag_y_q;

    if (coll_en) pix_valid_d = |coll_grant;
    if (load) begin
      pix_x_d    = tag_x_q[cidx];
      pix_y_d    = tag_y_q[cidx];
      pix_iter_d = eng_iter[cidx*HBI +: HBI];
    end

    // The engine still shows its previous result during its start cycle.
    for (int i = 0; i < NUM_ENGINES; i++) begin
      case (slot_q[i])
        SLOT_FREE: if (disp_grant[i]) begin
          slot_d[i]  = SLOT_BUSY;
          tag_x_d[i] = x_q;
          tag_y_d[i] = y_q;
        end
        SLOT_BUSY: if (!eng_start_q[i] && eng_ready[i]) slot_d[i] = SLOT_HOLD;
        SLOT_HOLD: if (load && coll_grant[i]) slot_d[i] = SLOT_FREE;
        default:   slot_d[i] = SLOT_FREE;
      endcase
    end

    case (state_q)
      ST_IDLE: if (frame_start) begin
        h_last_d = h_res - 1'b1;
        v_last_d = v_res - 1'b1;
        x_d      = '0;
        y_d      = '0;
        state_d  = (h_res == '0 || v_res == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (dispatch) begin
        if (x_q == h_last_q) begin
          x_d = '0;
          if (y_q == v_last_q) state_d = ST_DRAIN;
          else                 y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_DRAIN: if (all_free && !pix_valid_q) state_d = ST_DONE;
      ST_DONE: begin
        state_d      = ST_IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      h_last_q     <= '0;
      v_last_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      eng_start_q  <= '0;
      eng_x_q      <= '0;
      eng_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_iter_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_q[i]  <= SLOT_FREE;
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      h_last_q     <= h_last_d;
      v_last_q     <= v_last_d;
      x_q          <= x_d;
      y_q          <= y_d;
      eng_start_q  <= eng_start_d;
      eng_x_q      <= eng_x_d;
      eng_y_q      <= eng_y_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_iter_q   <= pix_iter_d;
      frame_done_q <= frame_done_d;
      slot_q       <= slot_d;
      tag_x_q      <= tag_x_d;
      tag_y_q      <= tag_y_d;
    end
  end

  assign frame_busy = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign eng_start  = eng_start_q;
  assign eng_x      = eng_x_q;
  assign eng_y      = eng_y_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_iter   = pix_iter_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mandel_scheduler.sv
// Bench for mandel_scheduler: behavioural engines, out-of-order scoreboard
// keyed by (x,y), directed frame scenarios plus randomized frames.
module tb_mandel_scheduler;
  import mandel_pkg::*;

  localparam int N   = 4;
  localparam int CW  = 12;
  localparam int HBI = 32;
  localparam int RW  = 2*CW + HBI;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [CW-1:0]    h_res, v_res;
  logic             frame_busy, frame_done;
  logic [N-1:0]     eng_start;
  logic [CW-1:0]    eng_x, eng_y;
  logic [N-1:0]     eng_ready;
  logic [N*HBI-1:0] eng_iter;
  logic             pix_valid, pix_ready;
  logic [CW-1:0]    pix_x, pix_y;
  logic [HBI-1:0]   pix_iter;
  fsm_t             dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  mandel_scheduler #(.NUM_ENGINES(N), .CW(CW), .HBI(HBI)) dut (
    .CLK        (clk),
    .RST        (rst),
    .frame_start(frame_start),
    .h_res      (h_res),
    .v_res      (v_res),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_ready  (eng_ready),
    .eng_iter   (eng_iter),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_iter   (pix_iter),
    .dbg_state  (dbg_state)
  );

  int checks = 0, fails = 0;
  int rec_cnt = 0, done_cnt = 0, start_cnt = 0, valid_cnt = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  bit lat0 = 1'b0, rand_ready = 1'b0, ready_level = 1'b1;
  logic [RW-1:0] exp_q[$];

  function automatic logic [HBI-1:0] ref_iter(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return HBI'(x) * HBI'(16) + HBI'(y);
  endfunction

  function automatic int ref_lat(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return lat0 ? 0 : (int'(x) + int'(y)) % 5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engines: result ready ref_lat cycles after the start edge.
  int             rem    [N] = '{default: 0};
  logic [HBI-1:0] iter_r [N] = '{default: '0};
  logic [N-1:0]   rdy = '0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (eng_start[i]) begin
        rem[i]    <= ref_lat(eng_x, eng_y);
        rdy[i]    <= (ref_lat(eng_x, eng_y) == 0);
        iter_r[i] <= ref_iter(eng_x, eng_y);
      end else if (!rdy[i]) begin
        rem[i] <= rem[i] - 1;
        if (rem[i] <= 1) rdy[i] <= 1'b1;
      end
    end
  end

  assign eng_ready = rdy;
  always_comb begin
    eng_iter = '0;
    for (int i = 0; i < N; i++) eng_iter[i*HBI +: HBI] = iter_r[i];
  end

  // writer back-pressure driver
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    logic          prev_stall;
    logic          prev_done;
    logic [RW-1:0] prev_rec;
    int            idx;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_rec   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (eng_start != '0) begin
          start_cnt++;
          check("start_onehot", $onehot(eng_start), 1);
          check("start_while_busy", frame_busy, 1);
        end
        if (prev_stall) begin
          check("stall_valid", pix_valid, 1);
          check("stall_data", {pix_x, pix_y, pix_iter}, prev_rec);
        end
        prev_stall = pix_valid && !pix_ready;
        prev_rec   = {pix_x, pix_y, pix_iter};
        if (pix_valid) valid_cnt++;
        if (pix_valid && pix_ready) begin
          rec_cnt++;
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j][RW-1:HBI] == {pix_x, pix_y}) idx = j;
          check("record_expected", (idx >= 0), 1);
          if (idx >= 0) begin
            check("record_iter", pix_iter, exp_q[idx][HBI-1:0]);
            exp_q.delete(idx);
          end
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_all_records", exp_q.size(), 0);
          check("done_single_pulse", prev_done, 0);
        end
        prev_done = frame_done;
      end
    end
  end

  // driver tasks
  task automatic start_frame(input int h, input int v);
    @(posedge clk);
    #1;
    h_res       = CW'(h);
    v_res       = CW'(v);
    frame_start = 1'b1;
    start_cyc   = cyc;
    for (int y = 0; y < v; y++)
      for (int x = 0; x < h; x++)
        exp_q.push_back({CW'(x), CW'(y), ref_iter(CW'(x), CW'(y))});
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", (done_cnt != d0), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run_frame(input string name, input int h, input int v);
    int r0 = rec_cnt, d0 = done_cnt;
    start_frame(h, v);
    wait_done(d0, 3000);
    check({name, "_records"}, rec_cnt - r0, h * v);
    check({name, "_done_count"}, done_cnt - d0, 1);
  endtask

  initial begin : main
    int s0, r0, d0, v0, h, v;
    rst = 1'b1; frame_start = 1'b0; h_res = '0; v_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_start", eng_start, 0);
    check("rst_engxy", {eng_x, eng_y}, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_pix", {pix_x, pix_y, pix_iter}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame("basic_4x2", 4, 2);

    lat0 = 1'b1;
    run_frame("lat0_8x1", 8, 1);
    lat0 = 1'b0;

    r0 = rec_cnt; d0 = done_cnt;
    start_frame(8, 4);
    repeat (6) @(posedge clk);
    ready_level = 1'b0;
    repeat (12) @(posedge clk);
    s0 = start_cnt;
    repeat (8) @(posedge clk);
    check("stall_no_start", start_cnt - s0, 0);
    @(negedge clk);
    check("stall_pix_valid", pix_valid, 1);
    ready_level = 1'b1;
    wait_done(d0, 3000);
    check("stall_records", rec_cnt - r0, 32);

    s0 = start_cnt; v0 = valid_cnt; d0 = done_cnt;
    start_frame(0, 5);
    wait_done(d0, 50);
    check("zero_done_latency", done_cyc - start_cyc, 2);
    check("zero_no_start", start_cnt - s0, 0);
    check("zero_no_valid", valid_cnt - v0, 0);

    r0 = rec_cnt; d0 = done_cnt;
    start_frame(4, 2);
    @(posedge clk);
    #1;
    h_res = CW'(1); v_res = CW'(1); frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_done(d0, 3000);
    check("busy_start_records", rec_cnt - r0, 8);
    check("busy_start_done_count", done_cnt - d0, 1);

    start_frame(8, 4);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", frame_busy, 0);
    check("midrst_start", eng_start, 0);
    check("midrst_valid", pix_valid, 0);
    check("midrst_pix", {pix_x, pix_y, pix_iter}, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame("after_rst_2x2", 2, 2);

    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      h = $urandom_range(1, 6);
      v = $urandom_range(1, 5);
      run_frame("random", h, v);
    end
    rand_ready = 1'b0;

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
